// File: rtl/wavetable_reader.sv
// wavetable_reader: phase accumulator that fetches table[idx] and table[idx+1] for lerp.
// Define WAVETABLE_READER_OVERRUN_EN to add a sticky overrun flag for dropped requests.
module wavetable_reader #(
    parameter int SAMPLE_BITS = 16,
    parameter int TABLE_BITS  = 8,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_BITS    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ACC_BITS-1:0]    increment,
    input  logic                   phase_reset,
    input  logic                   sample_req,
    output logic                   rd_en,
    output logic [TABLE_BITS-1:0]  rd_addr,
    input  logic [SAMPLE_BITS-1:0] rd_data,
    output logic [SAMPLE_BITS-1:0] a,
    output logic [SAMPLE_BITS-1:0] b,
    output logic [FRAC_BITS-1:0]   ratio,
    output logic                   valid,
    output logic                   busy
`ifdef WAVETABLE_READER_OVERRUN_EN
    ,
    output logic                   overrun
`endif
);
    generate
        if (ACC_BITS < TABLE_BITS + FRAC_BITS) begin : g_bad_acc
            $error("wavetable_reader: ACC_BITS must be >= TABLE_BITS+FRAC_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, CAPTURE_B} state_t;

    state_t                 state;
    logic [ACC_BITS-1:0]    acc;
    logic [TABLE_BITS-1:0]  idx_l;
    logic [FRAC_BITS-1:0]   frac_l;
    logic [SAMPLE_BITS-1:0] a_tmp;
    logic [ACC_BITS-1:0]    base;

    // A phase reset coinciding with an accept makes the fetch use phase 0.
    assign base = phase_reset ? '0 : acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            acc     <= '0;
            idx_l   <= '0;
            frac_l  <= '0;
            a_tmp   <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            a       <= '0;
            b       <= '0;
            ratio   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (phase_reset) acc <= '0;
            case (state)
                IDLE: if (sample_req) begin
                    idx_l   <= base[ACC_BITS-1 -: TABLE_BITS];
                    frac_l  <= base[ACC_BITS-TABLE_BITS-1 -: FRAC_BITS];
                    acc     <= base + increment;
                    rd_en   <= 1'b1;
                    rd_addr <= base[ACC_BITS-1 -: TABLE_BITS];
                    busy    <= 1'b1;
                    state   <= FETCH_A;
                end
                FETCH_A: begin
                    rd_addr <= idx_l + 1'b1;
                    state   <= FETCH_B;
                end
                FETCH_B: begin
                    a_tmp <= rd_data;
                    rd_en <= 1'b0;
                    state <= CAPTURE_B;
                end
                default: begin
                    a     <= a_tmp;
                    b     <= rd_data;
                    ratio <= frac_l;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WAVETABLE_READER_OVERRUN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun <= 1'b0;
        else if (sample_req && state != IDLE) overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_wavetable_reader.sv
// tb_wavetable_reader: directed + randomized checks of wavetable_reader against a phase model.
module tb_wavetable_reader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] increment = '0;
    logic        phase_reset = 1'b0;
    logic        sample_req = 1'b0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic [15:0] a, b;
    logic [7:0]  ratio;
    logic        valid, busy;
`ifdef WAVETABLE_READER_OVERRUN_EN
    logic        overrun;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] acc_m = '0;
    logic        ovr_m = 1'b0;
    logic [15:0] ram [256];

    wavetable_reader #(.SAMPLE_BITS(16), .TABLE_BITS(8), .FRAC_BITS(8), .ACC_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n), .increment(increment), .phase_reset(phase_reset),
        .sample_req(sample_req), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .a(a), .b(b), .ratio(ratio), .valid(valid), .busy(busy)
`ifdef WAVETABLE_READER_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ovr(input string tag);
`ifdef WAVETABLE_READER_OVERRUN_EN
        chk(tag, {31'd0, overrun}, {31'd0, ovr_m});
`endif
    endtask

    // One request, walked cycle by cycle; optionally pulse phase_reset mid-fetch
    // and issue a request at the final fetch edge that must be dropped.
    task automatic do_req(input logic [15:0] inc, input bit pr, input bit pr_busy, input bit drop);
        logic [15:0] base;
        logic [7:0]  e_idx, e_frac;
        @(negedge clk);
        sample_req = 1'b1; increment = inc; phase_reset = pr;
        base = pr ? 16'h0 : acc_m;
        e_idx = base[15:8];
        e_frac = base[7:0];
        acc_m = base + inc;
        @(negedge clk);
        sample_req = 1'b0; phase_reset = pr_busy; increment = 16'($urandom);
        if (pr_busy) acc_m = '0;
        chk("fa_rd_en", {31'd0, rd_en}, 1);
        chk("fa_rd_addr", {24'd0, rd_addr}, {24'd0, e_idx});
        chk("fa_busy", {31'd0, busy}, 1);
        @(negedge clk);
        phase_reset = 1'b0;
        chk("fb_rd_en", {31'd0, rd_en}, 1);
        chk("fb_rd_addr", {24'd0, rd_addr}, {24'd0, 8'(e_idx + 8'd1)});
        chk("fb_valid", {31'd0, valid}, 0);
        @(negedge clk);
        sample_req = drop;
        if (drop) ovr_m = 1'b1;
        chk("cb_rd_en", {31'd0, rd_en}, 0);
        chk("cb_rd_addr", {24'd0, rd_addr}, {24'd0, 8'(e_idx + 8'd1)});
        chk("cb_valid", {31'd0, valid}, 0);
        @(negedge clk);
        sample_req = 1'b0;
        chk("out_valid", {31'd0, valid}, 1);
        chk("out_a", {16'd0, a}, {16'd0, e_idx, 8'h00});
        chk("out_b", {16'd0, b}, {16'd0, 8'(e_idx + 8'd1), 8'h00});
        chk("out_ratio", {24'd0, ratio}, {24'd0, e_frac});
        chk("out_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("post_valid", {31'd0, valid}, 0);
        chk("post_a_hold", {16'd0, a}, {16'd0, e_idx, 8'h00});
        chk("post_busy", {31'd0, busy}, 0);
        chk_ovr("overrun");
    endtask

    initial begin
        int pulses, busy_low, last_v;
        logic [15:0] inc_h, base_h;
        for (int i = 0; i < 256; i++) ram[i] = 16'(i << 8);
        // Reset behaviour
        repeat (2) @(negedge clk);
        chk("rst_a", {16'd0, a}, 0);
        chk("rst_b", {16'd0, b}, 0);
        chk("rst_ratio", {24'd0, ratio}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_rd_addr", {24'd0, rd_addr}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", {31'd0, valid}, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_a", {16'd0, a}, 0);
        chk_ovr("idle_overrun");
        // Spaced requests, increment 0x0180
        do_req(16'h0180, 0, 0, 0);
        do_req(16'h0180, 0, 0, 0);
        // Index wrap, increment 0xFF40 from phase 0; follow-up fetch probes acc=0xFE80
        @(negedge clk); phase_reset = 1'b1; acc_m = '0;
        @(negedge clk); phase_reset = 1'b0;
        do_req(16'hFF40, 0, 0, 0);
        do_req(16'hFF40, 0, 0, 0);
        do_req(16'h0000, 0, 0, 0);
        // Continuous requests for 16 cycles
        inc_h = 16'h0123;
        @(negedge clk);
        sample_req = 1'b1; increment = inc_h;
        pulses = 0; busy_low = 0; last_v = -1;
        base_h = acc_m;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (valid) begin
                if (last_v >= 0) chk("hold_spacing", 32'(i - last_v), 4);
                last_v = i;
                pulses++;
                chk("hold_a", {16'd0, a}, {16'd0, base_h[15:8], 8'h00});
                chk("hold_ratio", {24'd0, ratio}, {24'd0, base_h[7:0]});
                base_h = base_h + inc_h;
            end
        end
        sample_req = 1'b0;
        acc_m = acc_m + 16'(inc_h * 4);
        ovr_m = 1'b1;
        chk("hold_pulses", 32'(pulses), 4);
        chk("hold_busy_low", 32'(busy_low), 4);
        chk("hold_acc", {16'd0, base_h}, {16'd0, acc_m});
        chk_ovr("hold_overrun");
        repeat (2) @(negedge clk);
        chk_ovr("hold_overrun_sticky");
        // phase_reset together with accept
        do_req(16'h5A00, 1, 0, 0);
        do_req(16'h0100, 1, 0, 0);
        do_req(16'(($urandom & 16'h7FFF)), 0, 0, 0);
        // Reset during FETCH_B
        @(negedge clk); sample_req = 1'b1; increment = 16'h1234;
        @(negedge clk); sample_req = 1'b0;
        @(negedge clk);
        chk("fb_before_rst", {31'd0, rd_en}, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_rd_en", {31'd0, rd_en}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_a", {16'd0, a}, 0);
        chk("arst_ratio", {24'd0, ratio}, 0);
        acc_m = '0; ovr_m = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk("arst_no_valid", 32'(pulses), 0);
        chk_ovr("arst_overrun");
        do_req(16'h0321, 0, 0, 0);
        // Randomized sequence
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_req(16'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 4) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
